// File: rtl/dro_driver.sv
// ---------------------------------------------------------------------------
// dro_driver
//
// Serialises a WIDTH-bit word, LSB first, into a destructive-readout (DRO)
// cell and checks each bit as it is read back.
//
// Each bit runs through SET, HOLD, READ, WAIT and SAMPLE:
//   - SET: pulse the set line if the bit is 1.
//   - READ: pulse the reset (readout) line.
//   - SAMPLE: check that the out line toggled exactly when the bit was 1.
// A pulse on set or reset is a single transition of that line.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   din        in   word to write (WIDTH bits, LSB first)
//   din_valid  in   din is valid
//   din_ready  out  high only in IDLE; a word is accepted when valid && ready
//   set        out  DRO set line (one transition per pulse)
//   reset      out  DRO reset/readout line (one transition per pulse)
//   out        in   DRO output line (one transition per readout pulse)
//   err_clr    in   synchronous clear of err_cnt, wins over an increment
//   done       out  one-cycle strobe in the last SAMPLE cycle of a word
//   err        out  one-cycle strobe in the SAMPLE cycle of a mismatched bit
//   err_cnt    out  saturating mismatch counter
// ---------------------------------------------------------------------------
module dro_driver #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_CYC = 3,
    parameter int unsigned READ_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             set,
    output logic             reset,
    input  logic             out,
    input  logic             err_clr,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Delay counters count down to zero, so they are loaded with length-1.
    localparam logic [3:0]      HoldLoad = 4'(HOLD_CYC - 1);
    localparam logic [3:0]      ReadLoad = 4'(READ_CYC - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSet,
        StHold,
        StRead,
        StWait,
        StSample
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] word_q;
    logic [IdxW-1:0]  idx_q;
    logic [3:0]       cnt_q;
    logic             out_prev_q;
    logic             set_q;
    logic             reset_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic [7:0]       err_cnt_q;

    logic cur_bit;
    logic last_bit;
    logic mismatch;

    assign cur_bit  = word_q[idx_q];
    assign last_bit = (idx_q == LastIdx);
    // The cell toggles its output on readout only when it held a 1.
    assign mismatch = ((out ^ out_prev_q) != cur_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            out_prev_q <= 1'b0;
            set_q      <= 1'b0;
            reset_q    <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (din_valid && ready_q) begin
                        word_q  <= din;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= StSet;
                    end
                end

                StSet: begin
                    if (cur_bit) begin
                        set_q <= ~set_q;
                    end
                    out_prev_q <= out;
                    cnt_q      <= HoldLoad;
                    state_q    <= StHold;
                end

                StHold: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StRead;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                StRead: begin
                    reset_q <= ~reset_q;
                    cnt_q   <= ReadLoad;
                    state_q <= StWait;
                end

                StWait: begin
                    if (cnt_q == 4'd0) begin
                        // out is evaluated on the edge into SAMPLE so that the
                        // registered err/done strobes are high during SAMPLE.
                        if (mismatch) begin
                            err_q <= 1'b1;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end
                        if (last_bit) begin
                            done_q <= 1'b1;
                        end
                        state_q <= StSample;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                StSample: begin
                    if (last_bit) begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        idx_q   <= idx_q + IdxW'(1);
                        state_q <= StSet;
                    end
                end

                default: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase

            // Placed after the increment so a clear in the same cycle wins.
            if (err_clr) begin
                err_cnt_q <= '0;
            end
        end
    end

    assign din_ready = ready_q;
    assign set       = set_q;
    assign reset     = reset_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dro_driver.sv
// ---------------------------------------------------------------------------
// tb_dro_driver
//
// Directed bench for dro_driver (WIDTH=8, HOLD_CYC=3, READ_CYC=4).
// A small DRO cell model drives out in one of three modes:
//   0 = ideal cell
//   1 = out stuck
//   2 = out toggles on every readout
// A table of words is applied with the expected toggle, err and latency
// counts. Hand-written sequences then cover saturation, clear-vs-increment,
// mid-word reset and back-to-back words.
// ---------------------------------------------------------------------------
module tb_dro_driver;

    localparam int unsigned W        = 8;
    localparam int unsigned H        = 3;
    localparam int unsigned R        = 4;
    localparam int          WORD_CYC = W * (H + R + 3);

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] din       = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       set;
    logic       reset;
    logic       out       = 1'b0;
    logic       err_clr   = 1'b0;
    logic       done;
    logic       err;
    logic [7:0] err_cnt;

    dro_driver #(
        .WIDTH   (W),
        .HOLD_CYC(H),
        .READ_CYC(R)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .set      (set),
        .reset    (reset),
        .out      (out),
        .err_clr  (err_clr),
        .done     (done),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // DRO cell model and line monitor, sampled just after each rising edge.
    int   mode    = 0;
    logic stored  = 1'b0;
    logic set_p   = 1'b0;
    logic reset_p = 1'b0;
    int   n_set   = 0;
    int   n_rst   = 0;
    int   n_both  = 0;
    int   n_err   = 0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            // Lines falling at reset are artefacts, not pulses.
            set_p   = set;
            reset_p = reset;
            stored  = 1'b0;
        end else begin
            if (set !== set_p && reset !== reset_p) n_both++;
            if (set !== set_p) begin
                n_set++;
                stored = 1'b1;
            end
            if (reset !== reset_p) begin
                n_rst++;
                if ((mode == 0 && stored) || mode == 2) out = ~out;
                stored = 1'b0;
            end
            set_p   = set;
            reset_p = reset;
        end
    end

    always @(negedge clk) begin
        if (rst_n && err) n_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called just after a negedge with the DUT in IDLE. Returns the number of
    // cycles from the handshake edge to the done cycle inclusive, and leaves
    // the caller at the negedge of the cycle after done.
    task automatic run_word(input logic [7:0] d, input int m, input logic clr, output int lat);
        mode      = m;
        n_set     = 0;
        n_rst     = 0;
        n_err     = 0;
        din       = d;
        din_valid = 1'b1;
        err_clr   = clr;
        check("ready_before_word", din_ready, 1);
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        din       = ~d;  // must be ignored mid-word
        lat       = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic clear_cnt();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    typedef struct {
        logic [7:0] din;
        int         mode;
        int         exp_set;
        int         exp_rst;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int lat2;

        vecs[0] = '{8'hA5, 0, 4, 8, 0};
        vecs[1] = '{8'h00, 1, 0, 8, 0};
        vecs[2] = '{8'hFF, 1, 8, 8, 8};
        vecs[3] = '{8'h3C, 0, 4, 8, 0};
        vecs[4] = '{8'h0F, 2, 4, 8, 4};
        vecs[5] = '{8'h81, 1, 2, 8, 2};
        vecs[6] = '{8'h5A, 2, 4, 8, 4};
        vecs[7] = '{8'h00, 2, 0, 8, 8};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_din_ready", din_ready, 1);
        check("rst_set", set, 0);
        check("rst_reset", reset, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;

        // Table-driven words; the first is accepted at the first edge after reset
        for (int i = 0; i < 8; i++) begin
            if (i > 0) clear_cnt();
            run_word(vecs[i].din, vecs[i].mode, 1'b0, lat);
            check($sformatf("v%0d_latency", i), lat, WORD_CYC);
            check($sformatf("v%0d_set_toggles", i), n_set, vecs[i].exp_set);
            check($sformatf("v%0d_reset_toggles", i), n_rst, vecs[i].exp_rst);
            check($sformatf("v%0d_err_strobes", i), n_err, vecs[i].exp_err);
            check($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
            check($sformatf("v%0d_ready_after", i), din_ready, 1);
        end

        // Saturation: 38 stuck words give 304 mismatches
        clear_cnt();
        for (int k = 0; k < 38; k++) begin
            run_word(8'hFF, 1, 1'b0, lat);
            if (k == 30) check("sat_cnt_248", err_cnt, 248);
        end
        check("sat_cnt_255", err_cnt, 255);

        // Clear held across every mismatch of a word
        run_word(8'hFF, 1, 1'b1, lat);
        check("clr_err_strobes", n_err, 8);
        check("clr_wins_cnt", err_cnt, 0);

        // Reset pulsed in HOLD of bit 3 (cycle 32 after handshake)
        mode      = 0;
        din       = 8'hA5;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (31) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_set", set, 0);
        check("midrst_reset", reset, 0);
        check("midrst_ready", din_ready, 1);
        check("midrst_done", done, 0);
        n_err = 0;
        lat   = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) lat++;
        end
        check("midrst_no_done", lat, 0);
        check("midrst_idle_ready", din_ready, 1);
        run_word(8'hA5, 0, 1'b0, lat);
        check("after_rst_latency", lat, WORD_CYC);
        check("after_rst_set_toggles", n_set, 4);
        check("after_rst_err", n_err, 0);

        // din_valid held high across two words
        mode      = 0;
        n_set     = 0;
        n_rst     = 0;
        n_err     = 0;
        din       = 8'h96;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din = 8'h3C;
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_latency", lat, WORD_CYC);
        @(negedge clk);
        check("b2b_gap_ready", din_ready, 1);
        @(negedge clk);
        check("b2b_second_accepted", din_ready, 0);
        din_valid = 1'b0;
        lat2      = 1;
        while (!done && lat2 < 200) begin
            @(negedge clk);
            lat2++;
        end
        check("b2b_second_latency", lat2, WORD_CYC);
        @(negedge clk);
        check("b2b_set_toggles", n_set, 8);
        check("b2b_reset_toggles", n_rst, 16);
        check("b2b_err", n_err, 0);

        check("no_simultaneous_toggle", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
